// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if
//   Command and response handshake bundle of the ALU command sequencer.
//   Ports:
//     cmd_valid_i / cmd_ready_o        command handshake
//     cmd_a_i, cmd_b_i, cmd_op_i,      command operands, opcode, caller tag
//     cmd_tag_i
//     rsp_valid_o / rsp_ready_i        response handshake
//     rsp_result_o, rsp_zero_o,        ALU result and flags with the command tag
//     rsp_carry_o, rsp_error_o,
//     rsp_tag_o
//   Modports: master = command producer / response consumer, slave = sequencer.
interface alu_cmd_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 4,
   parameter int TAG_W  = 4
);
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic [DATA_W-1:0] cmd_a_i;
   logic [DATA_W-1:0] cmd_b_i;
   logic [OP_W-1:0]   cmd_op_i;
   logic [TAG_W-1:0]  cmd_tag_i;

   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [DATA_W-1:0] rsp_result_o;
   logic              rsp_zero_o;
   logic              rsp_carry_o;
   logic              rsp_error_o;
   logic [TAG_W-1:0]  rsp_tag_o;

   modport master (
      output cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i, cmd_tag_i, rsp_ready_i,
      input  cmd_ready_o, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_carry_o,
             rsp_error_o, rsp_tag_o
   );

   modport slave (
      input  cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i, cmd_tag_i, rsp_ready_i,
      output cmd_ready_o, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_carry_o,
             rsp_error_o, rsp_tag_o
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Buffers tagged ALU commands, issues one per cycle into a registered ALU,
//   follows each through the fixed ALU latency and returns result + flags +
//   tag in issue order. Issue is credit-gated so the response FIFO can never
//   overflow.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     bus (slave)         command / response handshakes (alu_cmd_sequencer_if)
//     a_o, b_o, op_o      operands / opcode to the ALU (op_o = NOP_OP when idle)
//     issue_o             a_o/b_o/op_o carry a real command this cycle
//     result_i, zero_i,   ALU result and flags, valid ALU_LAT cycles after issue
//     carry_i, error_i
//     busy_o              anything queued, in flight or awaiting pop
module alu_cmd_sequencer #(
   parameter int DATA_W    = 8,
   parameter int OP_W      = 4,
   parameter int TAG_W     = 4,
   parameter int ALU_LAT   = 1,
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int NOP_OP    = 0
) (
   input  logic               clk,
   input  logic               rst,
   alu_cmd_sequencer_if.slave bus,
   output logic [DATA_W-1:0]  a_o,
   output logic [DATA_W-1:0]  b_o,
   output logic [OP_W-1:0]    op_o,
   output logic               issue_o,
   input  logic [DATA_W-1:0]  result_i,
   input  logic               zero_i,
   input  logic               carry_i,
   input  logic               error_i,
   output logic               busy_o
);
   localparam int CA = $clog2(CMD_DEPTH);
   localparam int RA = $clog2(RSP_DEPTH);

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] a;
   } cmd_t;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic              error;
      logic              carry;
      logic              zero;
      logic [DATA_W-1:0] result;
   } rsp_t;

   // command FIFO
   cmd_t        cmd_mem [CMD_DEPTH];
   logic [CA:0] cmd_wr, cmd_rd;
   logic        cmd_empty, cmd_full, cmd_push;
   cmd_t        cmd_head;

   // response FIFO
   rsp_t        rsp_mem [RSP_DEPTH];
   logic [RA:0] rsp_wr, rsp_rd, rsp_count;
   logic        rsp_empty, rsp_full, rsp_pop;
   rsp_t        rsp_head;

   // issue / in-flight tracking
   logic [RA:0]        inflight_q;
   logic [RA+1:0]      credit_used;
   logic               issue_go;
   logic               cap;
   logic [TAG_W-1:0]   tag_q;
   logic [ALU_LAT-1:0] pipe_vld;
   logic [TAG_W-1:0]   pipe_tag [ALU_LAT];

   assign cmd_empty = (cmd_wr == cmd_rd);
   assign cmd_full  = (cmd_wr[CA] != cmd_rd[CA]) && (cmd_wr[CA-1:0] == cmd_rd[CA-1:0]);
   assign cmd_push  = bus.cmd_valid_i && !cmd_full;
   assign cmd_head  = cmd_mem[cmd_rd[CA-1:0]];
   assign bus.cmd_ready_o = !cmd_full;

   assign rsp_empty = (rsp_wr == rsp_rd);
   assign rsp_full  = (rsp_wr[RA] != rsp_rd[RA]) && (rsp_wr[RA-1:0] == rsp_rd[RA-1:0]);
   assign rsp_count = rsp_wr - rsp_rd;
   assign rsp_pop   = !rsp_empty && bus.rsp_ready_i;
   assign rsp_head  = rsp_mem[rsp_rd[RA-1:0]];

   // A credit is held from the issue decision until the response is popped,
   // so every issued command already owns a response FIFO slot.
   assign credit_used = {1'b0, inflight_q} + {1'b0, rsp_count};
   assign issue_go    = !cmd_empty && (credit_used < (RA+2)'(RSP_DEPTH));
   assign cap         = pipe_vld[ALU_LAT-1];

   always_ff @(posedge clk) begin
      if (cmd_push) begin
         cmd_mem[cmd_wr[CA-1:0]] <= '{tag: bus.cmd_tag_i, op: bus.cmd_op_i,
                                      b: bus.cmd_b_i, a: bus.cmd_a_i};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_wr <= '0;
         cmd_rd <= '0;
      end else begin
         if (cmd_push) cmd_wr <= cmd_wr + (CA+1)'(1);
         if (issue_go) cmd_rd <= cmd_rd + (CA+1)'(1);
      end
   end

   // Issue registers: operands hold their last value when idle, only the
   // opcode is forced to NOP so the ALU sees a harmless operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_o     <= '0;
         b_o     <= '0;
         op_o    <= OP_W'(NOP_OP);
         issue_o <= 1'b0;
         tag_q   <= '0;
      end else begin
         issue_o <= issue_go;
         if (issue_go) begin
            a_o   <= cmd_head.a;
            b_o   <= cmd_head.b;
            op_o  <= cmd_head.op;
            tag_q <= cmd_head.tag;
         end else begin
            op_o  <= OP_W'(NOP_OP);
         end
      end
   end

   // Stage 0 is loaded at the end of the issue cycle; the last stage is valid
   // in the cycle the ALU presents the matching result.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= issue_o;
         for (int i = 1; i < ALU_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      pipe_tag[0] <= tag_q;
      for (int i = 1; i < ALU_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= '0;
      end else begin
         case ({issue_go, cap})
            2'b10:   inflight_q <= inflight_q + (RA+1)'(1);
            2'b01:   inflight_q <= inflight_q - (RA+1)'(1);
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (cap) begin
         rsp_mem[rsp_wr[RA-1:0]] <= '{tag: pipe_tag[ALU_LAT-1], error: error_i,
                                      carry: carry_i, zero: zero_i, result: result_i};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_wr <= '0;
         rsp_rd <= '0;
      end else begin
         if (cap)     rsp_wr <= rsp_wr + (RA+1)'(1);
         if (rsp_pop) rsp_rd <= rsp_rd + (RA+1)'(1);
      end
   end

   // Response fields read as zero while the FIFO is empty.
   always_comb begin
      bus.rsp_valid_o  = !rsp_empty;
      bus.rsp_result_o = '0;
      bus.rsp_zero_o   = 1'b0;
      bus.rsp_carry_o  = 1'b0;
      bus.rsp_error_o  = 1'b0;
      bus.rsp_tag_o    = '0;
      if (!rsp_empty) begin
         bus.rsp_result_o = rsp_head.result;
         bus.rsp_zero_o   = rsp_head.zero;
         bus.rsp_carry_o  = rsp_head.carry;
         bus.rsp_error_o  = rsp_head.error;
         bus.rsp_tag_o    = rsp_head.tag;
      end
   end

   assign busy_o = !cmd_empty || (inflight_q != '0) || !rsp_empty;

   a_no_rsp_overflow: assert property (@(posedge clk) disable iff (rst) cap |-> !rsp_full);

endmodule
